crc_serial_lfsr: RTL and testbench
==================================

Name: crc_serial_lfsr

Overview:
- Bit-serial CRC-8 generator built on an 8-bit LFSR (internal Galois form).
- Data enters one bit per clock while `active` is high.
- When `active` drops, the 8-bit CRC is shifted out LSB-first on `crc`, with `valid` high for exactly 8 cycles.
- Sits at the tail of a serial transmit path and appends the CRC to a framed bitstream.

Parameters:
- WIDTH, 8, CRC/LFSR width in bits.
- SEED, 8'hD8, LFSR value loaded at reset and at the end of every output phase.
- TAPS, 8'b0100_0100, feedback tap mask; bits 2 and 6 set.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low; clears state immediately on assertion.
- data  in  1  serial message bit; sampled on the rising edge when active=1.
- active  in  1  high for each message bit; its falling edge ends the message.
- valid  out  1  high while crc carries a CRC bit.
- crc  out  1  serial CRC output, LSB first.

Behaviour:
- Reset (rst=0): lfsr=SEED, state=IDLE, cnt=0, valid=0, crc=0. All outputs are registered.
- State machine states: IDLE, SHIFT, OUT.
- IDLE:
  - active=1 -> absorb the data bit this cycle and go to SHIFT.
  - active=0 -> hold; valid=0, crc=0.
- Absorb step (every clock where active=1 in IDLE or SHIFT):
  - fb = data ^ lfsr[0].
  - lfsr[7] <= fb.
  - For N=1..7: lfsr[N-1] <= lfsr[N] ^ (TAPS[N] & fb).
- SHIFT:
  - active=1 -> absorb.
  - active=0 -> go to OUT with cnt=0; lfsr is not updated.
  - A message of one active cycle is legal.
- OUT (lasts 8 cycles):
  - Each clock: crc <= lfsr[0], lfsr <= lfsr >> 1 (zero fill), valid <= 1, cnt++.
  - The first CRC bit (lfsr[0]) is registered on the first OUT clock; valid and the CRC bits are then visible for 8 consecutive cycles.
  - After the 8th bit is emitted, go to IDLE.
  - On that transition: valid <= 0, crc <= 0, lfsr <= SEED, ready for the next message without an external reset.
- active is ignored during OUT; no abort and no new absorption. A new message starts only from IDLE.
- Output contract: the bit emitted in the k-th valid cycle (k=0..7) equals bit k of the final LFSR value.
- Reset mid-operation (any state): immediate return to the reset values; partial CRC discarded.
- data is don't-care when active=0.
- No valid pulse ever occurs without at least one absorbed bit.

Decomposition:
- Package crc_pkg: WIDTH, SEED, TAPS constants and the state enum {IDLE, SHIFT, OUT}.
- One natural sub-module: crc_lfsr_core.
  - Holds the 8-bit register.
  - Provides a next-state function for absorb and for shift-out, plus a seed-load input.
- The top level keeps the FSM, the 3-bit counter and the output registers.

Test Plan:
- Reset only, active held 0 for 20 cycles -> valid stays 0, crc stays 0.
- Message 8'h00 sent LSB-first (8 active cycles), then active=0 -> valid high exactly 8 cycles; crc bits k=0..7 = 0,1,1,0,1,1,0,0 (CRC 8'h36).
- Ten random bytes, each LSB-first, with reset between messages -> collected 8-bit CRC matches the bit-accurate reference model (SEED D8, TAPS 44) for every byte; valid width is exactly 8 cycles each time.
- Two back-to-back messages without reset, next message starting the cycle after valid falls -> the second CRC equals the CRC of that message alone (proves reseed).
- Reset asserted during SHIFT after 4 bits, and again during OUT after 3 CRC bits -> outputs go to 0 asynchronously; the following full 8'h00 message still yields 8'h36.
- active pulsed high during OUT -> ignored; the CRC stream completes unchanged and the FSM returns to IDLE.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared constants and enumerations for the bit-serial CRC-8 generator.
package crc_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SEED = 8'hD8;
  localparam logic [WIDTH-1:0] TAPS = 8'b0100_0100;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    OUT
  } state_t;

  // Operation requested of the LFSR core for the coming clock edge.
  typedef enum logic [1:0] {
    OP_HOLD,
    OP_ABSORB,
    OP_SHIFT_OUT,
    OP_LOAD_SEED
  } lfsr_op_t;

endpackage

// File: rtl/crc_lfsr_core.sv
// Galois-form LFSR register: absorbs message bits, shifts the result out,
// or reloads the seed, as selected by the controlling FSM.
module crc_lfsr_core #(
  parameter int               WIDTH = crc_pkg::WIDTH,
  parameter logic [WIDTH-1:0] SEED  = crc_pkg::SEED,
  parameter logic [WIDTH-1:0] TAPS  = crc_pkg::TAPS
) (
  input  logic              clk,
  input  logic              rst,
  input  crc_pkg::lfsr_op_t op,
  input  logic              data,
  output logic              lsb
);
  import crc_pkg::*;

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;

  // Feedback enters at the top; tapped positions fold it in as they shift down.
  function automatic logic [WIDTH-1:0] absorb(input logic [WIDTH-1:0] cur,
                                               input logic             bit_in);
    logic             fb;
    logic [WIDTH-1:0] nxt;
    fb  = bit_in ^ cur[0];
    nxt = '0;
    nxt[WIDTH-1] = fb;
    for (int n = 1; n < WIDTH; n++) begin
      nxt[n-1] = cur[n] ^ (TAPS[n] & fb);
    end
    return nxt;
  endfunction

  always_comb begin
    lfsr_d = lfsr_q;
    case (op)
      OP_ABSORB:    lfsr_d = absorb(lfsr_q, data);
      OP_SHIFT_OUT: lfsr_d = lfsr_q >> 1;
      OP_LOAD_SEED: lfsr_d = SEED;
      default:      lfsr_d = lfsr_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= SEED;
    else      lfsr_q <= lfsr_d;
  end

  assign lsb = lfsr_q[0];

endmodule

// File: rtl/crc_serial_lfsr.sv
// Bit-serial CRC-8 generator: absorbs data while active is high, then emits
// the CRC LSB-first with valid high for WIDTH cycles and reseeds itself.
module crc_serial_lfsr #(
  parameter int               WIDTH = crc_pkg::WIDTH,
  parameter logic [WIDTH-1:0] SEED  = crc_pkg::SEED,
  parameter logic [WIDTH-1:0] TAPS  = crc_pkg::TAPS
) (
  input  logic clk,
  input  logic rst,
  input  logic data,
  input  logic active,
  output logic valid,
  output logic crc
);
  import crc_pkg::*;

  localparam int CW = $clog2(WIDTH);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_d, crc_d;
  lfsr_op_t      op;
  logic          lfsr_lsb;

  crc_lfsr_core #(
    .WIDTH (WIDTH),
    .SEED  (SEED),
    .TAPS  (TAPS)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .op   (op),
    .data (data),
    .lsb  (lfsr_lsb)
  );

  // The seed reload rides on the last output clock so the register is ready
  // for a new message on the very first IDLE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op      = OP_HOLD;
    valid_d = 1'b0;
    crc_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (active) begin
          op      = OP_ABSORB;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (active) begin
          op = OP_ABSORB;
        end else begin
          state_d = OUT;
          cnt_d   = '0;
        end
      end
      OUT: begin
        valid_d = 1'b1;
        crc_d   = lfsr_lsb;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          op      = OP_LOAD_SEED;
          state_d = IDLE;
        end else begin
          op = OP_SHIFT_OUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid   <= 1'b0;
      crc     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid   <= valid_d;
      crc     <= crc_d;
    end
  end

endmodule

// File: tb/tb_crc_serial_lfsr.sv
// Self-checking bench for crc_serial_lfsr against a reflected-polynomial CRC model.
module tb_crc_serial_lfsr;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic data = 1'b0;
  logic active = 1'b0;
  logic valid;
  logic crc;

  int n_cmp = 0;
  int n_err = 0;

  crc_serial_lfsr dut (
    .clk    (clk),
    .rst    (rst),
    .data   (data),
    .active (active),
    .valid  (valid),
    .crc    (crc)
  );

  always #5 clk = ~clk;

  // Reflected polynomial: x^8 term plus taps 2 and 6 moved down one place.
  localparam logic [7:0] POLY_REFL = 8'hA2;
  localparam logic [7:0] SEED_REF  = 8'hD8;

  function automatic logic [7:0] crc_ref(input logic [15:0] msg, input int nbits);
    logic [7:0] r;
    r = SEED_REF;
    for (int i = 0; i < nbits; i++) begin
      if ((msg[i] ^ r[0]) == 1'b1) r = (r >> 1) ^ POLY_REFL;
      else                         r = r >> 1;
    end
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] msg, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      active = 1'b1;
      data   = msg[i];
    end
    @(negedge clk);
    active = 1'b0;
    data   = $urandom_range(0, 1);
  endtask

  // Samples on negedges until valid has risen and fallen (bounded); an
  // optional one-cycle active pulse is injected during the output phase.
  task automatic collect(output logic [7:0] got, output int width, input int poke_at);
    bit seen;
    got   = '0;
    width = 0;
    seen  = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      active = 1'b0;
      if (valid === 1'b1) begin
        seen = 1;
        if (width < 8) got[width] = crc;
        width++;
        if (width == poke_at) begin
          active = 1'b1;
          data   = $urandom_range(0, 1);
        end
      end else if (seen) begin
        break;
      end
    end
  endtask

  logic [7:0] got;
  int         width;
  logic [15:0] msg;
  int          nb;

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_output($sformatf("idle_out_%0d", i), {30'd0, valid, crc}, 32'd0);
    end

    apply_stimulus(16'h0000, 8);
    collect(got, width, 0);
    check_output("zero_msg_crc", got, 8'h36);
    check_output("zero_msg_width", width, 8);
    check_output("model_zero", crc_ref(16'h0000, 8), 8'h36);

    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      msg = 16'($urandom_range(0, 255));
      apply_stimulus(msg, 8);
      collect(got, width, 0);
      check_output($sformatf("rand_crc_%0d_msg_%02h", t, msg[7:0]), got, crc_ref(msg, 8));
      check_output($sformatf("rand_width_%0d", t), width, 8);
    end

    msg = 16'($urandom_range(0, 255));
    apply_stimulus(msg, 8);
    collect(got, width, 0);
    check_output("b2b_first", got, crc_ref(msg, 8));
    msg = 16'($urandom_range(0, 255));
    active = 1'b1;
    data   = msg[0];
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      data = msg[i];
    end
    @(negedge clk);
    active = 1'b0;
    collect(got, width, 0);
    check_output("b2b_second", got, crc_ref(msg, 8));
    check_output("b2b_width", width, 8);

    msg = 16'h0001;
    apply_stimulus(msg, 1);
    collect(got, width, 0);
    check_output("one_bit_crc", got, crc_ref(msg, 1));
    check_output("one_bit_width", width, 8);

    msg = 16'($urandom);
    nb  = $urandom_range(9, 16);
    apply_stimulus(msg, nb);
    collect(got, width, 0);
    check_output("long_msg_crc", got, crc_ref(msg, nb));

    apply_stimulus(16'h00F5, 4);
    #2 rst = 1'b0;
    #1 check_output("rst_in_shift", {30'd0, valid, crc}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(16'h0000, 8);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (valid !== 1'b1) c--;
      if ($time > 2000000) break;
    end
    check_output("pre_rst_valid", valid, 1'b1);
    #2 rst = 1'b0;
    #1 check_output("rst_in_out", {30'd0, valid, crc}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_output("after_rst_quiet", valid, 1'b0);
    end
    apply_stimulus(16'h0000, 8);
    collect(got, width, 0);
    check_output("post_rst_crc", got, 8'h36);
    check_output("post_rst_width", width, 8);

    msg = 16'($urandom_range(0, 255));
    apply_stimulus(msg, 8);
    collect(got, width, 3);
    check_output("poke_crc", got, crc_ref(msg, 8));
    check_output("poke_width", width, 8);
    repeat (5) begin
      @(negedge clk);
      check_output("poke_idle", valid, 1'b0);
    end
    msg = 16'($urandom_range(0, 255));
    apply_stimulus(msg, 8);
    collect(got, width, 0);
    check_output("poke_next_crc", got, crc_ref(msg, 8));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
